// File: rtl/logic_op_bist.sv
// rtl/logic_op_bist.sv - self-test driver/checker for the registered 8-bit AND/OR logic unit
module logic_op_bist #(
    parameter int          NUM_VECTORS = 256,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  dut_a,
    output logic [7:0]  dut_b,
    output logic        dut_mode,
    output logic        dut_rst_n,
    input  logic [7:0]  dut_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic        first_fail_valid,
    output logic [15:0] first_fail_idx
);

    typedef enum logic [1:0] {IDLE, RST_CHK, RUN, DRAIN} state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] TAPS     = 16'hB400;

    state_t      state, state_nx;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;
    logic [15:0] idx;
    logic [7:0]  exp_q;
    logic [15:0] exp_idx;
    logic        exp_valid;
    logic        accept;
    logic        cmp_en;
    logic [7:0]  cmp_ref;
    logic [15:0] fail_idx;
    logic [7:0]  expected;
    logic        mismatch;

    assign accept    = (state == IDLE) && start;
    assign lfsr_nx   = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
    assign busy      = (state != IDLE);
    assign pass      = done && (err_count == 16'h0000);
    assign dut_rst_n = rst && (state != RST_CHK);
    assign expected  = dut_mode ? (dut_a | dut_b) : (dut_a & dut_b);
    assign mismatch  = cmp_en && (dut_result != cmp_ref);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dut_a    = 8'h00;
        dut_b    = 8'h00;
        dut_mode = 1'b0;
        cmp_en   = 1'b0;
        cmp_ref  = 8'h00;
        fail_idx = exp_idx;
        case (state)
            IDLE: begin
                if (start) state_nx = RST_CHK;
            end
            RST_CHK: begin
                state_nx = RUN;
            end
            RUN: begin
                dut_a    = lfsr[15:8];
                dut_b    = lfsr[7:0];
                dut_mode = idx[0];
                // First RUN cycle observes the unit straight out of its synchronous reset.
                if (idx == 16'h0000) begin
                    cmp_en   = 1'b1;
                    cmp_ref  = 8'h00;
                    fail_idx = 16'hFFFF;
                end else begin
                    cmp_en   = exp_valid;
                    cmp_ref  = exp_q;
                end
                if (idx == LAST_IDX) state_nx = DRAIN;
            end
            DRAIN: begin
                cmp_en   = exp_valid;
                cmp_ref  = exp_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr             <= SEED;
            idx              <= 16'h0000;
            exp_q            <= 8'h00;
            exp_idx          <= 16'h0000;
            exp_valid        <= 1'b0;
            done             <= 1'b0;
            err_count        <= 16'h0000;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 16'h0000;
        end else if (accept) begin
            lfsr             <= SEED;
            idx              <= 16'h0000;
            exp_valid        <= 1'b0;
            done             <= 1'b0;
            err_count        <= 16'h0000;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 16'h0000;
        end else begin
            if (state == RUN) begin
                lfsr      <= lfsr_nx;
                idx       <= idx + 16'd1;
                exp_q     <= expected;
                exp_idx   <= idx;
                exp_valid <= 1'b1;
            end
            if (state == DRAIN) begin
                done      <= 1'b1;
                exp_valid <= 1'b0;
            end
            if (mismatch) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= fail_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_op_bist.sv
// tb/tb_logic_op_bist.sv - scoreboard bench for logic_op_bist with a fault-injectable logic unit
module tb_logic_op_bist;

    localparam int NV = 4;

    typedef struct {
        int          blen;
        logic        pass;
        logic [15:0] err;
        logic        ffv;
        logic [15:0] ffi;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  dut_a, dut_b, dut_result;
    logic        dut_mode, dut_rst_n;
    logic        busy, done, pass, first_fail_valid;
    logic [15:0] err_count, first_fail_idx;

    int   checks = 0;
    int   errors = 0;
    int   fault  = 0;
    res_t res_q[$];
    vec_t vec_q[$];

    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    int   bcnt = 0;
    int   rc = NV;

    logic_op_bist #(.NUM_VECTORS(NV), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_mode(dut_mode), .dut_rst_n(dut_rst_n),
        .dut_result(dut_result), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    // Logic unit model; fault 1 = AND in both modes, fault 2 = ignores reset and shows 8'h55.
    always_ff @(posedge clk) begin
        if (!dut_rst_n)      dut_result <= (fault == 2) ? 8'h55 : 8'h00;
        else if (fault == 1) dut_result <= dut_a & dut_b;
        else                 dut_result <= dut_mode ? (dut_a | dut_b) : (dut_a & dut_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        res_t r;
        vec_t v;
        if (busy) bcnt = prev_busy ? bcnt + 1 : 1;
        if (busy && !dut_rst_n) begin
            rc = 0;
        end else if (busy && rc < NV) begin
            if (vec_q.size() > 0) begin
                v = vec_q.pop_front();
                chk("vec_a", {24'h0, dut_a}, {24'h0, v.a});
                chk("vec_b", {24'h0, dut_b}, {24'h0, v.b});
                chk("vec_mode", {31'h0, dut_mode}, {31'h0, v.m});
            end
            rc++;
        end else if (!busy) begin
            rc = NV;
        end
        if (done && !prev_done) begin
            if (res_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                r = res_q.pop_front();
                chk("busy_len", bcnt, r.blen);
                chk("pass", {31'h0, pass}, {31'h0, r.pass});
                chk("err_count", {16'h0, err_count}, {16'h0, r.err});
                chk("ff_valid", {31'h0, first_fail_valid}, {31'h0, r.ffv});
                chk("ff_idx", {16'h0, first_fail_idx}, {16'h0, r.ffi});
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    task automatic push_vecs();
        vec_q.push_back('{8'hAC, 8'hE1, 1'b0});
        vec_q.push_back('{8'hE2, 8'h70, 1'b1});
        vec_q.push_back('{8'h71, 8'h38, 1'b0});
        vec_q.push_back('{8'h38, 8'h9C, 1'b1});
    endtask

    task automatic push_res(input int bl, input logic p, input logic [15:0] e,
                            input logic v, input logic [15:0] i);
        res_t r;
        r.blen = bl; r.pass = p; r.err = e; r.ffv = v; r.ffi = i;
        res_q.push_back(r);
    endtask

    // Leaves the bench at #1 after the accepting edge (state RST_CHK).
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 40; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
    endtask

    initial begin
        #2;
        chk("rst_dut_rst_n", {31'h0, dut_rst_n}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_err", {16'h0, err_count}, 32'd0);
        chk("rst_ffv", {31'h0, first_fail_valid}, 32'd0);
        chk("rst_a", {24'h0, dut_a}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // golden unit with vector check
        fault = 0;
        push_vecs();
        push_res(6, 1'b1, 16'h0000, 1'b0, 16'h0000);
        pulse_start();
        chk("rstchk_dut_rst_n", {31'h0, dut_rst_n}, 32'd0);
        wait_done();

        // unit ANDs in OR mode
        fault = 1;
        push_res(6, 1'b0, 16'd2, 1'b1, 16'd1);
        pulse_start();
        chk("start_after_done_done", {31'h0, done}, 32'd0);
        wait_done();

        // unit ignores its reset
        fault = 2;
        push_res(6, 1'b0, 16'd1, 1'b1, 16'hFFFF);
        pulse_start();
        chk("counters_cleared", {16'h0, err_count}, 32'd0);
        chk("ffv_cleared", {31'h0, first_fail_valid}, 32'd0);
        wait_done();

        // start pulsed mid-RUN is ignored
        fault = 0;
        push_res(6, 1'b1, 16'h0000, 1'b0, 16'h0000);
        pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("no_retrigger", {31'h0, busy}, 32'd0);

        // rst asserted in the third RUN cycle
        pulse_start();
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_done", {31'h0, done}, 32'd0);
        chk("abort_a", {24'h0, dut_a}, 32'd0);
        chk("abort_b", {24'h0, dut_b}, 32'd0);
        chk("abort_dut_rst_n", {31'h0, dut_rst_n}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        push_vecs();
        push_res(6, 1'b1, 16'h0000, 1'b0, 16'h0000);
        pulse_start();
        wait_done();

        chk("vec_q_drained", vec_q.size(), 32'd0);
        chk("res_q_drained", res_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
